// File: rtl/fetch_controller.sv
// fetch_controller
// Instruction fetch sequencer for the 32-bit MIPS core. Owns the program
// counter, addresses the combinational InstructionMemory, and registers each
// fetched word into the IF/ID stage behind a valid/ready handshake.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   imem_addr / imem_instr word address out, instruction back (same cycle)
//   if_instr, if_pc        registered instruction and its word address
//   if_valid / id_ready    IF/ID handshake toward decode
//   branch_taken/_target   redirect from EX (wins over jump)
//   jump / jump_target     redirect from ID
//   halt                   HALT_INSTR seen, fetch stopped until reset
//   fetch_count            instructions delivered into IF/ID (wraps)
module fetch_controller #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_valid,
   input  logic        id_ready,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        halt,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

   state_t      state;
   logic [31:0] pc;

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         if_instr    <= 32'h0;
         if_pc       <= 32'h0;
         if_valid    <= 1'b0;
         halt        <= 1'b0;
         fetch_count <= 32'h0;
      end else begin
         case (state)
            // Single dead cycle after reset; redirects are ignored here.
            BOOT: state <= FETCH;

            FETCH: begin
               if (branch_taken || jump) begin
                  // Redirect flushes IF/ID, including a stalled valid word.
                  pc       <= branch_taken ? branch_target : jump_target;
                  if_valid <= 1'b0;
               end else if (!if_valid || id_ready) begin
                  if (imem_instr == HALT_INSTR) begin
                     // Halt word is never delivered; pc stays on it.
                     state    <= HALTED;
                     halt     <= 1'b1;
                     if_valid <= 1'b0;
                  end else begin
                     if_instr    <= imem_instr;
                     if_pc       <= pc;
                     if_valid    <= 1'b1;
                     pc          <= pc + 32'd1;
                     fetch_count <= fetch_count + 32'd1;
                  end
               end
               // Otherwise stalled: everything holds.
            end

            HALTED: begin
               if_valid <= 1'b0;
               halt     <= 1'b1;
            end

            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
// Directed bench for fetch_controller. Instruction memory is modelled as
// word(A) = 32'h1000_0000 + A, except at halt_addr where HALT_INSTR sits.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        id_ready = 1'b1;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        halt;
   logic [31:0] fetch_count;

   logic [31:0] halt_addr = 32'h0000_1000;
   int          vecs = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   assign imem_instr = (imem_addr == halt_addr) ? 32'hFFFF_FFFF
                                                : 32'h1000_0000 + imem_addr;

   fetch_controller dut (
      .clk(clk), .reset(reset),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
      .id_ready(id_ready),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .halt(halt), .fetch_count(fetch_count)
   );

   // One rising edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset, release, and run through BOOT; next step is the first fetch edge.
   task automatic restart();
      reset = 1'b1; id_ready = 1'b1; branch_taken = 1'b0; jump = 1'b0;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL rst_imem_addr got %h exp %h", imem_addr, 32'h0); end
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL rst_if_valid got %b exp 0", if_valid); end
      vecs++; if (halt !== 1'b0) begin errs++; $display("FAIL rst_halt got %b exp 0", halt); end
      vecs++; if (fetch_count !== 32'h0) begin errs++; $display("FAIL rst_fetch_count got %0d exp 0", fetch_count); end
      vecs++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin errs++; $display("FAIL rst_if_regs got %h/%h exp 0/0", if_instr, if_pc); end
      reset = 1'b0;
      step();  // BOOT edge
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL boot_if_valid got %b exp 0", if_valid); end
      vecs++; if (imem_addr !== 32'h0) begin errs++; $display("FAIL boot_imem_addr got %h exp 0", imem_addr); end
   endtask

   task automatic test_sequential();
      restart();
      for (int i = 0; i < 4; i++) begin
         step();
         vecs++;
         if (if_valid !== 1'b1 || if_pc !== 32'(i) || if_instr !== 32'h1000_0000 + 32'(i)) begin
            errs++;
            $display("FAIL seq_%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                     i, if_valid, if_pc, if_instr, 32'(i), 32'h1000_0000 + 32'(i));
         end
      end
      vecs++; if (fetch_count !== 32'd4) begin errs++; $display("FAIL seq_fetch_count got %0d exp 4", fetch_count); end
   endtask

   task automatic test_backpressure();
      restart();
      step(); step(); step();  // if_pc 0,1,2
      vecs++; if (if_pc !== 32'h2 || if_valid !== 1'b1) begin errs++; $display("FAIL bp_setup got pc=%h v=%b exp pc=2 v=1", if_pc, if_valid); end
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         vecs++;
         if (if_valid !== 1'b1 || if_pc !== 32'h2 || if_instr !== 32'h1000_0002 ||
             imem_addr !== 32'h3 || fetch_count !== 32'd3) begin
            errs++;
            $display("FAIL bp_stall_%0d got v=%b pc=%h instr=%h addr=%h cnt=%0d exp 1/2/10000002/3/3",
                     i, if_valid, if_pc, if_instr, imem_addr, fetch_count);
         end
      end
      id_ready = 1'b1;
      step();
      vecs++; if (if_pc !== 32'h3 || if_instr !== 32'h1000_0003) begin errs++; $display("FAIL bp_release got pc=%h instr=%h exp 3/10000003", if_pc, if_instr); end
      vecs++; if (fetch_count !== 32'd4) begin errs++; $display("FAIL bp_release_cnt got %0d exp 4", fetch_count); end
   endtask

   task automatic test_redirect();
      // Runs on from test_backpressure: fetch_count = 4, if_pc = 3.
      branch_taken = 1'b1; branch_target = 32'h40;
      jump = 1'b1; jump_target = 32'h80;
      step();
      branch_taken = 1'b0; jump = 1'b0;
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL br_bubble got v=%b exp 0", if_valid); end
      vecs++; if (imem_addr !== 32'h40) begin errs++; $display("FAIL br_priority got addr=%h exp 40", imem_addr); end
      vecs++; if (fetch_count !== 32'd4) begin errs++; $display("FAIL br_cnt got %0d exp 4", fetch_count); end
      step();
      vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h1000_0040) begin errs++; $display("FAIL br_target got v=%b pc=%h instr=%h exp 1/40/10000040", if_valid, if_pc, if_instr); end
      jump = 1'b1; jump_target = 32'h80;
      step();
      jump = 1'b0;
      vecs++; if (if_valid !== 1'b0 || imem_addr !== 32'h80) begin errs++; $display("FAIL jmp_bubble got v=%b addr=%h exp 0/80", if_valid, imem_addr); end
      step();
      vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin errs++; $display("FAIL jmp_target got v=%b pc=%h exp 1/80", if_valid, if_pc); end
      vecs++; if (fetch_count !== 32'd6) begin errs++; $display("FAIL jmp_cnt got %0d exp 6", fetch_count); end
   endtask

   task automatic test_halt();
      halt_addr = 32'h5;
      restart();
      for (int i = 0; i < 5; i++) step();
      vecs++; if (if_pc !== 32'h4 || if_valid !== 1'b1 || halt !== 1'b0) begin errs++; $display("FAIL halt_pre got pc=%h v=%b h=%b exp 4/1/0", if_pc, if_valid, halt); end
      step();
      vecs++; if (halt !== 1'b1 || if_valid !== 1'b0) begin errs++; $display("FAIL halt_set got h=%b v=%b exp 1/0", halt, if_valid); end
      vecs++; if (imem_addr !== 32'h5 || fetch_count !== 32'd5) begin errs++; $display("FAIL halt_state got addr=%h cnt=%0d exp 5/5", imem_addr, fetch_count); end
      branch_taken = 1'b1; branch_target = 32'h40;
      step();
      branch_taken = 1'b0;
      step();
      vecs++; if (halt !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h5 || fetch_count !== 32'd5) begin
         errs++; $display("FAIL halt_ignore_br got h=%b v=%b addr=%h cnt=%0d exp 1/0/5/5", halt, if_valid, imem_addr, fetch_count);
      end
      halt_addr = 32'h0000_1000;
   endtask

   task automatic test_wrap();
      restart();
      step();  // if_pc 0
      jump = 1'b1; jump_target = 32'hFFFF_FFFF;
      step();
      jump = 1'b0;
      step();
      vecs++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFF || if_instr !== 32'h0FFF_FFFF) begin errs++; $display("FAIL wrap_top got v=%b pc=%h instr=%h exp 1/ffffffff/0fffffff", if_valid, if_pc, if_instr); end
      step();
      vecs++; if (if_pc !== 32'h0 || imem_addr !== 32'h1) begin errs++; $display("FAIL wrap_zero got pc=%h addr=%h exp 0/1", if_pc, imem_addr); end
   endtask

   task automatic test_mid_reset();
      restart();
      step(); step();  // if_pc 1, fetch_count 2
      id_ready = 1'b0;
      step();          // stalled valid
      vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h1) begin errs++; $display("FAIL mr_stall got v=%b pc=%h exp 1/1", if_valid, if_pc); end
      reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
      step();
      vecs++; if (if_valid !== 1'b0 || halt !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'h0 ||
                  if_pc !== 32'h0 || if_instr !== 32'h0) begin
         errs++; $display("FAIL mr_reset got v=%b h=%b addr=%h cnt=%0d pc=%h instr=%h exp all 0",
                          if_valid, halt, imem_addr, fetch_count, if_pc, if_instr);
      end
      reset = 1'b0; branch_taken = 1'b0; id_ready = 1'b1;
      step();          // BOOT again
      vecs++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin errs++; $display("FAIL mr_boot got v=%b addr=%h exp 0/0", if_valid, imem_addr); end
      step();
      vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || fetch_count !== 32'd1) begin errs++; $display("FAIL mr_first got v=%b pc=%h cnt=%0d exp 1/0/1", if_valid, if_pc, fetch_count); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
